// File: rtl/spi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// spi_burst_ctrl
// Burst sequencer placed in front of a byte-level SPI master. A host issues a
// burst command (byte count); this block frames the transfer with chip select,
// feeds host TX bytes to the master one at a time (exactly one outstanding),
// returns each received byte to the host, and enforces cs_n setup, hold and
// minimum idle gap.
//
// Ports:
//   clk, rstn                     clock (rising edge), async active-low reset
//   start, len[7:0]               burst command, accepted only while busy=0
//   busy, done, cs_n              status and chip select (all registered)
//   host_tx_data/valid/ready      host -> block byte stream (ready = FETCH)
//   host_rx_data/valid            block -> host received bytes, no backpressure
//   m_tx_data/valid/ready         block -> SPI master byte handshake
//   m_rx_data/valid               SPI master -> block received byte pulse
// -----------------------------------------------------------------------------
module spi_burst_ctrl #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    input  logic [7:0] host_tx_data,
    input  logic       host_tx_valid,
    output logic       host_tx_ready,
    output logic [7:0] host_rx_data,
    output logic       host_rx_valid,
    output logic [7:0] m_tx_data,
    output logic       m_tx_valid,
    input  logic       m_tx_ready,
    input  logic [7:0] m_rx_data,
    input  logic       m_rx_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        FETCH   = 3'd2,
        SEND    = 3'd3,
        WAIT_RX = 3'd4,
        HOLD    = 3'd5,
        GAP     = 3'd6
    } state_e;

    // Terminal values of the shared phase counter for each timed state.
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rem_q, rem_d;
    logic       cs_n_q, cs_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] m_tx_data_q, m_tx_data_d;
    logic       m_tx_valid_q, m_tx_valid_d;
    logic [7:0] host_rx_data_q, host_rx_data_d;
    logic       host_rx_valid_q, host_rx_valid_d;

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        cs_n_d          = cs_n_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        m_tx_data_d     = m_tx_data_q;
        m_tx_valid_d    = m_tx_valid_q;
        host_rx_data_d  = host_rx_data_q;
        host_rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // busy is always low here, so a start while busy never reaches this branch.
                if (start) begin
                    rem_d  = len;
                    busy_d = 1'b1;
                    cnt_d  = 8'd0;
                    if (len != 8'd0) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        // Empty transaction: skip the frame, cs_n never asserts.
                        state_d = GAP;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = FETCH;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FETCH: begin
                if (host_tx_valid) begin
                    m_tx_data_d  = host_tx_data;
                    m_tx_valid_d = 1'b1;
                    state_d      = SEND;
                end else begin
                    state_d = FETCH;
                end
            end
            SEND: begin
                if (m_tx_ready) begin
                    m_tx_valid_d = 1'b0;
                    state_d      = WAIT_RX;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT_RX: begin
                if (m_rx_valid) begin
                    host_rx_data_d  = m_rx_data;
                    host_rx_valid_d = 1'b1;
                    // Saturating decrement keeps a corrupted count from wrapping to 255.
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q - 8'd1;
                    end else begin
                        rem_d = 8'd0;
                    end
                    if (rem_q <= 8'd1) begin
                        state_d = HOLD;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = WAIT_RX;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = 8'd0;
                rem_d        = 8'd0;
                cs_n_d       = 1'b1;
                busy_d       = 1'b0;
                m_tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops cs_n and any in-flight byte at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            rem_q           <= 8'd0;
            cs_n_q          <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            m_tx_data_q     <= 8'd0;
            m_tx_valid_q    <= 1'b0;
            host_rx_data_q  <= 8'd0;
            host_rx_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rem_q           <= rem_d;
            cs_n_q          <= cs_n_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            m_tx_data_q     <= m_tx_data_d;
            m_tx_valid_q    <= m_tx_valid_d;
            host_rx_data_q  <= host_rx_data_d;
            host_rx_valid_q <= host_rx_valid_d;
        end
    end

    assign host_tx_ready = (state_q == FETCH);
    assign busy          = busy_q;
    assign done          = done_q;
    assign cs_n          = cs_n_q;
    assign m_tx_data     = m_tx_data_q;
    assign m_tx_valid    = m_tx_valid_q;
    assign host_rx_data  = host_rx_data_q;
    assign host_rx_valid = host_rx_valid_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_ctrl
// Directed self-checking bench for spi_burst_ctrl (CS_SETUP=CS_HOLD=CS_IDLE=2).
// The bench plays both the host and the SPI master; expected values are
// hand-computed constants or simple expressions of the bytes the bench drives.
// -----------------------------------------------------------------------------
module tb_spi_burst_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic [7:0] m_tx_data;
    logic       m_tx_valid;
    logic       m_tx_ready;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // Event counters sampled on each rising edge.
    int   hs_cnt   = 0;
    int   rx_cnt   = 0;
    int   done_cnt = 0;
    int   cs_rise  = 0;
    int   cs_fall  = 0;
    logic cs_prev  = 1'b1;

    int hs0, rx0, done0, rise0, fall0;

    spi_burst_ctrl #(
        .CS_SETUP(2),
        .CS_HOLD (2),
        .CS_IDLE (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .cs_n         (cs_n),
        .host_tx_data (host_tx_data),
        .host_tx_valid(host_tx_valid),
        .host_tx_ready(host_tx_ready),
        .host_rx_data (host_rx_data),
        .host_rx_valid(host_rx_valid),
        .m_tx_data    (m_tx_data),
        .m_tx_valid   (m_tx_valid),
        .m_tx_ready   (m_tx_ready),
        .m_rx_data    (m_rx_data),
        .m_rx_valid   (m_rx_valid)
    );

    always #5 clk = ~clk;

    // Count handshakes, RX pulses, done pulses and chip-select edges.
    always @(posedge clk) begin
        if (m_tx_valid && m_tx_ready) hs_cnt <= hs_cnt + 1;
        if (host_rx_valid) rx_cnt <= rx_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (cs_n && !cs_prev) cs_rise <= cs_rise + 1;
        if (!cs_n && cs_prev) cs_fall <= cs_fall + 1;
        cs_prev <= cs_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        hs0   = hs_cnt;
        rx0   = rx_cnt;
        done0 = done_cnt;
        rise0 = cs_rise;
        fall0 = cs_fall;
    endtask

    task automatic start_burst(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Host side: wait (bounded) for FETCH, optionally stall, then offer one byte.
    task automatic host_send(input logic [7:0] tx, input int stall);
        int n = 0;
        while (!host_tx_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", {31'd0, host_tx_ready}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            host_tx_valid = 1'b0;
            tick();
            chk("fetch_stall_ready", {31'd0, host_tx_ready}, 32'd1);
            chk("fetch_stall_cs", {31'd0, cs_n}, 32'd0);
        end
        host_tx_valid = 1'b1;
        host_tx_data  = tx;
        tick();
        host_tx_valid = 1'b0;
        chk("m_tx_valid_up", {31'd0, m_tx_valid}, 32'd1);
        chk("m_tx_data", {24'd0, m_tx_data}, {24'd0, tx});
    endtask

    // Master side: hold off ready for some cycles, then accept the byte.
    task automatic master_take(input int stall, input logic [7:0] tx);
        for (int i = 0; i < stall; i++) begin
            m_tx_ready = 1'b0;
            tick();
            chk("send_stall_valid", {31'd0, m_tx_valid}, 32'd1);
            chk("send_stall_data", {24'd0, m_tx_data}, {24'd0, tx});
            chk("send_stall_cs", {31'd0, cs_n}, 32'd0);
        end
        m_tx_ready = 1'b1;
        tick();
        m_tx_ready = 1'b0;
        chk("m_tx_valid_down", {31'd0, m_tx_valid}, 32'd0);
    endtask

    // Master returns a byte; host must see it exactly one cycle later, once.
    task automatic master_return(input logic [7:0] rx, input logic [7:0] exp);
        m_rx_valid = 1'b1;
        m_rx_data  = rx;
        tick();
        m_rx_valid = 1'b0;
        chk("rx_valid", {31'd0, host_rx_valid}, 32'd1);
        chk("rx_data", {24'd0, host_rx_data}, {24'd0, exp});
        tick();
        chk("rx_valid_pulse", {31'd0, host_rx_valid}, 32'd0);
    endtask

    task automatic do_byte(input logic [7:0] tx, input logic [7:0] rx, input logic [7:0] exp,
                           input int tx_stall, input int rdy_stall);
        host_send(tx, tx_stall);
        master_take(rdy_stall, tx);
        master_return(rx, exp);
    endtask

    // Called in the second HOLD cycle (one cycle after the last host_rx_valid).
    task automatic finish_burst();
        chk("hold_cs_low", {31'd0, cs_n}, 32'd0);
        chk("hold_no_done", {31'd0, done}, 32'd0);
        tick();
        chk("gap_cs_high", {31'd0, cs_n}, 32'd1);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("done_single", {31'd0, done}, 32'd0);
        chk("gap_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        start         = 1'b0;
        len           = 8'd0;
        host_tx_data  = 8'd0;
        host_tx_valid = 1'b0;
        m_tx_ready    = 1'b0;
        m_rx_data     = 8'd0;
        m_rx_valid    = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tx_ready", {31'd0, host_tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, host_rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, host_rx_data}, 32'd0);
        chk("rst_m_valid", {31'd0, m_tx_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_tx_data}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        // ---- single byte, host offers 0xA5 early (must not be taken in SETUP) ----
        snap();
        host_tx_valid = 1'b1;
        host_tx_data  = 8'hA5;
        start_burst(8'd1);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        chk("s1_cs_low", {31'd0, cs_n}, 32'd0);
        chk("s1_setup_noready", {31'd0, host_tx_ready}, 32'd0);
        chk("s1_setup_nomtx", {31'd0, m_tx_valid}, 32'd0);
        tick();
        chk("s1_setup2_noready", {31'd0, host_tx_ready}, 32'd0);
        chk("s1_setup2_nomtx", {31'd0, m_tx_valid}, 32'd0);
        tick();
        chk("s1_fetch_ready", {31'd0, host_tx_ready}, 32'd1);
        do_byte(8'hA5, 8'h3C, 8'h3C, 0, 0);
        finish_burst();
        chk("s1_handshakes", hs_cnt - hs0, 32'd1);
        chk("s1_dones", done_cnt - done0, 32'd1);

        // ---- burst of 4, master echoes inverted ----
        begin
            logic [7:0] exp4 [4];
            logic [7:0] tx;
            exp4[0] = 8'hFE; exp4[1] = 8'hFD; exp4[2] = 8'hFC; exp4[3] = 8'hFB;
            snap();
            start_burst(8'd4);
            for (int i = 0; i < 4; i++) begin
                tx = 8'(i + 1);
                do_byte(tx, ~tx, exp4[i], 0, 0);
            end
            finish_burst();
            chk("b4_handshakes", hs_cnt - hs0, 32'd4);
            chk("b4_rx_pulses", rx_cnt - rx0, 32'd4);
            chk("b4_cs_falls", cs_fall - fall0, 32'd1);
            chk("b4_cs_rises", cs_rise - rise0, 32'd1);
            chk("b4_dones", done_cnt - done0, 32'd1);
        end

        // ---- backpressure: host stalls 5, master stalls 10 ----
        snap();
        start_burst(8'd2);
        do_byte(8'h55, 8'h66, 8'h66, 5, 10);
        do_byte(8'h77, 8'h88, 8'h88, 5, 10);
        finish_burst();
        chk("bp_handshakes", hs_cnt - hs0, 32'd2);
        chk("bp_cs_falls", cs_fall - fall0, 32'd1);

        // ---- len = 0 ----
        snap();
        start_burst(8'd0);
        chk("z_busy", {31'd0, busy}, 32'd1);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_cs_high", {31'd0, cs_n}, 32'd1);
        tick();
        chk("z_done_pulse", {31'd0, done}, 32'd0);
        chk("z_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("z_idle", {31'd0, busy}, 32'd0);
        chk("z_cs_never_low", cs_fall - fall0, 32'd0);
        chk("z_no_handshake", hs_cnt - hs0, 32'd0);

        // ---- start while busy is ignored ----
        snap();
        start_burst(8'd3);
        start = 1'b1;
        len   = 8'd7;
        tick();
        start = 1'b0;
        do_byte(8'h11, 8'h21, 8'h21, 0, 0);
        do_byte(8'h12, 8'h22, 8'h22, 0, 0);
        do_byte(8'h13, 8'h23, 8'h23, 0, 0);
        finish_burst();
        chk("sb_handshakes", hs_cnt - hs0, 32'd3);
        chk("sb_dones", done_cnt - done0, 32'd1);

        // ---- reset during WAIT_RX of byte 2 of 4 ----
        start_burst(8'd4);
        do_byte(8'h31, 8'h41, 8'h41, 0, 0);
        host_send(8'h32, 0);
        master_take(0, 8'h32);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_cs_n", {31'd0, cs_n}, 32'd1);
        chk("ar_m_valid", {31'd0, m_tx_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        m_rx_valid = 1'b1;
        m_rx_data  = 8'hEE;
        tick();
        m_rx_valid = 1'b0;
        tick();
        chk("ar_no_rx", {31'd0, host_rx_valid}, 32'd0);
        rstn = 1'b1;
        tick();
        snap();
        start_burst(8'd1);
        do_byte(8'h5C, 8'hC5, 8'hC5, 0, 0);
        finish_burst();
        chk("ar_rx_pulses", rx_cnt - rx0, 32'd1);

        // ---- stray m_rx_valid in IDLE and SETUP ----
        snap();
        m_rx_valid = 1'b1;
        m_rx_data  = 8'h99;
        tick();
        m_rx_valid = 1'b0;
        chk("st_idle_rx", {31'd0, host_rx_valid}, 32'd0);
        start_burst(8'd1);
        m_rx_valid = 1'b1;
        tick();
        m_rx_valid = 1'b0;
        chk("st_setup_rx", {31'd0, host_rx_valid}, 32'd0);
        do_byte(8'h44, 8'hBB, 8'hBB, 0, 0);
        finish_burst();
        chk("st_rx_pulses", rx_cnt - rx0, 32'd1);

        // ---- len = 255 ----
        snap();
        start_burst(8'd255);
        for (int i = 0; i < 255; i++) begin
            do_byte(8'(i), 8'(i) ^ 8'h5A, 8'(i) ^ 8'h5A, 0, 0);
        end
        finish_burst();
        chk("l255_rx_pulses", rx_cnt - rx0, 32'd255);
        chk("l255_handshakes", hs_cnt - hs0, 32'd255);
        chk("l255_dones", done_cnt - done0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
